pixel_port_arbiter: RTL and testbench

- Shares the single LT24Display pixel interface (xAddr/yAddr/pixelData/pixelWrite/pixelReady) between two pixel producers.
  - Requester 0: full-frame board/sprite renderer.
  - Requester 1: clock-banner updater.
- Burst-locked, round-robin grant with a bounded burst length so neither producer can starve the other.
- Sits between the renderers and LT24Display in the chess top level; also rejects out-of-range coordinates.

---
 rtl/pixel_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_pixel_port_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_port_arbiter.sv
// Two-requester, burst-locked round-robin arbiter for the LT24Display pixel port.
// Optional grant-stall revocation is compiled in with `define PIXEL_ARB_TIMEOUT_EN.
module pixel_port_arbiter #(
  parameter int LCD_WIDTH  = 240,
  parameter int LCD_HEIGHT = 320,
  parameter int MAX_BURST  = 240,
  parameter int TIMEOUT    = 16
) (
  input  logic        clock,
  input  logic        resetApp_n,
  input  logic        req0Valid,
  input  logic        req0Last,
  input  logic [7:0]  req0X,
  input  logic [8:0]  req0Y,
  input  logic [15:0] req0Data,
  output logic        req0Ready,
  input  logic        req1Valid,
  input  logic        req1Last,
  input  logic [7:0]  req1X,
  input  logic [8:0]  req1Y,
  input  logic [15:0] req1Data,
  output logic        req1Ready,
  output logic [7:0]  xAddr,
  output logic [8:0]  yAddr,
  output logic [15:0] pixelData,
  output logic        pixelWrite,
  input  logic        pixelReady,
  output logic [1:0]  grant,
  output logic        rangeError
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, GAP} state_t;

  localparam logic [8:0] X_LIMIT    = 9'(LCD_WIDTH);
  localparam logic [9:0] Y_LIMIT    = 10'(LCD_HEIGHT);
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  state_t     state_q, state_d;
  logic [7:0] beat_cnt_q, beat_cnt_d;
  logic       rr_q, rr_d;
  logic       range_err_q, range_err_d;

  logic        own_valid, own_last, in_grant, in_range, accept, release_burst;
  logic [7:0]  own_x;
  logic [8:0]  own_y;
  logic [15:0] own_data;
  logic        stall_hit;

  // Only the owner's beat ever reaches the display; everything else reads as zero.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_x     = '0;
    own_y     = '0;
    own_data  = '0;
    case (state_q)
      GRANT0: begin
        own_valid = req0Valid;
        own_last  = req0Last;
        own_x     = req0X;
        own_y     = req0Y;
        own_data  = req0Data;
      end
      GRANT1: begin
        own_valid = req1Valid;
        own_last  = req1Last;
        own_x     = req1X;
        own_y     = req1Y;
        own_data  = req1Data;
      end
      IDLE, GAP: ;
    endcase
  end

  assign in_grant   = (state_q == GRANT0) || (state_q == GRANT1);
  assign in_range   = ({1'b0, own_x} < X_LIMIT) && ({1'b0, own_y} < Y_LIMIT);
  assign accept     = own_valid && (pixelReady || !in_range);

  assign xAddr      = own_x;
  assign yAddr      = own_y;
  assign pixelData  = own_data;
  assign pixelWrite = own_valid && in_range;
  assign req0Ready  = (state_q == GRANT0) && accept;
  assign req1Ready  = (state_q == GRANT1) && accept;
  assign grant      = {state_q == GRANT1, state_q == GRANT0};
  assign rangeError = range_err_q;

`ifdef PIXEL_ARB_TIMEOUT_EN
  localparam logic [4:0] STALL_LAST = 5'(TIMEOUT - 1);

  logic [4:0] stall_q, stall_d;

  always_comb begin
    stall_d   = '0;
    stall_hit = 1'b0;
    if (in_grant && !own_valid) begin
      if (stall_q == STALL_LAST) stall_hit = 1'b1;
      else                       stall_d   = stall_q + 5'd1;
    end
  end

  always_ff @(posedge clock or negedge resetApp_n) begin
    if (!resetApp_n) stall_q <= '0;
    else             stall_q <= stall_d;
  end
`else
  localparam int unused_timeout = TIMEOUT;
  assign stall_hit = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    beat_cnt_d    = beat_cnt_q;
    rr_d          = rr_q;
    range_err_d   = range_err_q;
    release_burst = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0Valid && req1Valid) state_d = rr_q ? GRANT1 : GRANT0;
        else if (req0Valid)         state_d = GRANT0;
        else if (req1Valid)         state_d = GRANT1;
      end
      GRANT0, GRANT1: begin
        if (accept) begin
          if (!in_range) range_err_d = 1'b1;
          // A last beat landing on the burst limit still releases only once.
          if (own_last || (beat_cnt_q == BURST_LAST)) release_burst = 1'b1;
          else                                        beat_cnt_d    = beat_cnt_q + 8'd1;
        end
        if (stall_hit) release_burst = 1'b1;
        if (release_burst) begin
          state_d    = GAP;
          beat_cnt_d = '0;
          rr_d       = (state_q == GRANT0);
        end
      end
      GAP: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetApp_n) begin
    if (!resetApp_n) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      rr_q        <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      rr_q        <= rr_d;
      range_err_q <= range_err_d;
    end
  end

endmodule

// File: tb/tb_pixel_port_arbiter.sv
// Scoreboard bench for pixel_port_arbiter: per-requester beat queues, a cycle monitor
// applying the arbitration rules, and an expected-write queue per requester.
module tb_pixel_port_arbiter;
  localparam int LCD_WIDTH  = 240;
  localparam int LCD_HEIGHT = 320;
  localparam int MAX_BURST  = 240;
  localparam int TIMEOUT    = 16;

  logic        clock = 1'b0;
  logic        resetApp_n;
  logic        req0Valid, req0Last, req0Ready, req1Valid, req1Last, req1Ready;
  logic [7:0]  req0X, req1X, xAddr;
  logic [8:0]  req0Y, req1Y, yAddr;
  logic [15:0] req0Data, req1Data, pixelData;
  logic        pixelWrite, pixelReady, rangeError;
  logic [1:0]  grant;

  always #5 clock = ~clock;

  pixel_port_arbiter #(
    .LCD_WIDTH(LCD_WIDTH), .LCD_HEIGHT(LCD_HEIGHT), .MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .resetApp_n(resetApp_n),
    .req0Valid(req0Valid), .req0Last(req0Last), .req0X(req0X), .req0Y(req0Y),
    .req0Data(req0Data), .req0Ready(req0Ready),
    .req1Valid(req1Valid), .req1Last(req1Last), .req1X(req1X), .req1Y(req1Y),
    .req1Data(req1Data), .req1Ready(req1Ready),
    .xAddr(xAddr), .yAddr(yAddr), .pixelData(pixelData), .pixelWrite(pixelWrite),
    .pixelReady(pixelReady), .grant(grant), .rangeError(rangeError)
  );

  typedef struct {
    logic [7:0]  x;
    logic [8:0]  y;
    logic [15:0] d;
    logic        last;
  } beat_t;

  beat_t src0[$], src1[$], exp0[$], exp1[$];
  int n_tests = 0;
  int n_fail  = 0;
  int vprob0 = 100, vprob1 = 100, rprob = 100;
  bit drv_en = 1'b0, hold0 = 1'b0, tk0 = 1'b0, tk1 = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic bit in_rng(input beat_t b);
    return (int'(b.x) < LCD_WIDTH) && (int'(b.y) < LCD_HEIGHT);
  endfunction

  task automatic push_beat(input int r, input beat_t b);
    if (r == 0) begin
      src0.push_back(b);
      if (in_rng(b)) exp0.push_back(b);
    end else begin
      src1.push_back(b);
      if (in_rng(b)) exp1.push_back(b);
    end
  endtask

  task automatic add(input int r, input int n, input bit lastf, input int oor_pct);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.x = 8'($urandom_range(LCD_WIDTH - 1));
      b.y = 9'($urandom_range(LCD_HEIGHT - 1));
      b.d = 16'($urandom);
      if ($urandom_range(99) < oor_pct) begin
        if ($urandom_range(1) == 1) b.x = 8'($urandom_range(255, LCD_WIDTH));
        else                        b.y = 9'($urandom_range(511, LCD_HEIGHT));
      end
      b.last = lastf && (i == n - 1);
      push_beat(r, b);
    end
  endtask

  task automatic drain(input int budget);
    int c = 0;
    while ((src0.size() + src1.size() + exp0.size() + exp1.size()) != 0 && c < budget) begin
      @(posedge clock);
      c++;
    end
    if (c >= budget) fail_now("drain_timeout");
    repeat (4) @(posedge clock);
  endtask

  task automatic wait_src0_le(input int n, input int budget);
    int c = 0;
    while (src0.size() > n && c < budget) begin
      @(posedge clock);
      c++;
    end
    if (c >= budget) fail_now("wait_src0_timeout");
  endtask

  // Requester driver: retire the accepted beat, then present the next one.
  initial begin
    beat_t b;
    forever begin
      @(posedge clock);
      #1;
      if (!resetApp_n || !drv_en) begin
        req0Valid = 1'b0;
        req1Valid = 1'b0;
        pixelReady = 1'b1;
        continue;
      end
      if (tk0 && src0.size() > 0) b = src0.pop_front();
      if (tk1 && src1.size() > 0) b = src1.pop_front();
      pixelReady = ($urandom_range(99) < rprob);
      if (src0.size() > 0) begin
        req0Valid = !hold0 && ($urandom_range(99) < vprob0);
        req0X = src0[0].x; req0Y = src0[0].y; req0Data = src0[0].d; req0Last = src0[0].last;
      end else begin
        req0Valid = 1'b0;
        req0X = 8'($urandom); req0Y = 9'($urandom); req0Data = 16'($urandom);
        req0Last = 1'($urandom);
      end
      if (src1.size() > 0) begin
        req1Valid = ($urandom_range(99) < vprob1);
        req1X = src1[0].x; req1Y = src1[0].y; req1Data = src1[0].d; req1Last = src1[0].last;
      end else begin
        req1Valid = 1'b0;
        req1X = 8'($urandom); req1Y = 9'($urandom); req1Data = 16'($urandom);
        req1Last = 1'($urandom);
      end
    end
  end

  // Monitor: arbitration rules applied to observed inputs, writes checked against queues.
  initial begin
    logic [1:0]  m_g;
    bit          m_pref, m_rerr, m_gap, ov, ol, inr, acc, rel;
    int          m_beats, m_idle;
    logic [7:0]  ox;
    logic [8:0]  oy;
    logic [15:0] od;
    beat_t       e;
    m_g = 2'b00; m_pref = 1'b0; m_rerr = 1'b0; m_gap = 1'b0; m_beats = 0; m_idle = 0;
    forever begin
      @(negedge clock);
      if (!resetApp_n) begin
        chk("rst_grant", grant, 2'b00);
        chk("rst_pixelWrite", pixelWrite, 1'b0);
        chk("rst_ready", {req0Ready, req1Ready}, 2'b00);
        chk("rst_addr_data", {xAddr, yAddr, pixelData}, '0);
        chk("rst_rangeError", rangeError, 1'b0);
        m_g = 2'b00; m_pref = 1'b0; m_rerr = 1'b0; m_gap = 1'b0; m_beats = 0; m_idle = 0;
        tk0 = 1'b0; tk1 = 1'b0;
        continue;
      end
      chk("grant", grant, m_g);
      ov = 1'b0; ol = 1'b0; ox = '0; oy = '0; od = '0;
      if (m_g == 2'b01) begin
        ov = req0Valid; ol = req0Last; ox = req0X; oy = req0Y; od = req0Data;
      end else if (m_g == 2'b10) begin
        ov = req1Valid; ol = req1Last; ox = req1X; oy = req1Y; od = req1Data;
      end
      inr = (int'(ox) < LCD_WIDTH) && (int'(oy) < LCD_HEIGHT);
      acc = ov && (pixelReady || !inr);
      chk("out_addr_data", {xAddr, yAddr, pixelData}, {ox, oy, od});
      chk("pixelWrite", pixelWrite, ov && inr);
      chk("req0Ready", req0Ready, (m_g == 2'b01) && acc);
      chk("req1Ready", req1Ready, (m_g == 2'b10) && acc);
      chk("rangeError", rangeError, m_rerr);
      if (pixelWrite && pixelReady) begin
        if (m_g == 2'b01 && exp0.size() > 0) begin
          e = exp0.pop_front();
          chk("xfer0", {xAddr, yAddr, pixelData}, {e.x, e.y, e.d});
        end else if (m_g == 2'b10 && exp1.size() > 0) begin
          e = exp1.pop_front();
          chk("xfer1", {xAddr, yAddr, pixelData}, {e.x, e.y, e.d});
        end else fail_now("xfer_unexpected");
      end
      tk0 = req0Valid && req0Ready;
      tk1 = req1Valid && req1Ready;
      if (m_g != 2'b00) begin
        rel = 1'b0;
        if (acc) begin
          if (!inr) m_rerr = 1'b1;
          if (ol || (m_beats + 1 == MAX_BURST)) rel = 1'b1;
          else m_beats++;
        end
`ifdef PIXEL_ARB_TIMEOUT_EN
        if (ov) m_idle = 0;
        else begin
          m_idle++;
          if (m_idle == TIMEOUT) rel = 1'b1;
        end
`endif
        if (rel) begin
          m_beats = 0; m_idle = 0;
          m_pref = (m_g == 2'b01);
          m_g = 2'b00;
          m_gap = 1'b1;
        end
      end else if (m_gap) begin
        m_gap = 1'b0;
      end else begin
        if (req0Valid && req1Valid) m_g = m_pref ? 2'b10 : 2'b01;
        else if (req0Valid)         m_g = 2'b01;
        else if (req1Valid)         m_g = 2'b10;
      end
    end
  end

  initial begin
    #900000;
    fail_now("watchdog");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    beat_t b;
    resetApp_n = 1'b0;
    req0Valid = 1'b0; req0Last = 1'b0; req0X = '0; req0Y = '0; req0Data = '0;
    req1Valid = 1'b0; req1Last = 1'b0; req1X = '0; req1Y = '0; req1Data = '0;
    pixelReady = 1'b1;
    repeat (3) @(posedge clock);
    #2 resetApp_n = 1'b1;
    repeat (2) @(posedge clock);

    // Single requester, 10-beat burst
    add(0, 10, 1'b1, 0);
    drv_en = 1'b1;
    drain(200);

    // Both requesters with single-beat bursts: alternating ownership
    add(0, 1, 1'b1, 0); add(0, 1, 1'b1, 0);
    add(1, 1, 1'b1, 0); add(1, 1, 1'b1, 0);
    drain(200);

    // req1 long stream forced off at the burst limit while req0 waits
    add(1, 300, 1'b1, 0);
    repeat (3) @(posedge clock);
    add(0, 5, 1'b1, 0);
    drain(1000);

    // Out-of-range beats are consumed and latch rangeError
    add(0, 2, 1'b0, 0);
    b.x = 8'd240; b.y = 9'd5; b.d = 16'hBEEF; b.last = 1'b0;
    push_beat(0, b);
    b.x = 8'd10; b.y = 9'd320; b.d = 16'h1234; b.last = 1'b0;
    push_beat(0, b);
    add(0, 2, 1'b1, 0);
    drain(200);

    // Downstream back-pressure
    rprob = 50;
    add(0, 4, 1'b1, 0);
    drain(400);
    rprob = 100;

    // Owner stalls mid-burst while the other requester waits
    add(0, 6, 1'b1, 0);
    wait_src0_le(4, 200);
    hold0 = 1'b1;
    add(1, 3, 1'b1, 0);
    repeat (40) @(posedge clock);
    hold0 = 1'b0;
    drain(400);

    // Randomized traffic
    for (int r = 0; r < 8; r++) begin
      vprob0 = $urandom_range(100, 60);
      vprob1 = $urandom_range(100, 60);
      rprob  = $urandom_range(100, 40);
      for (int k = 0; k < 3; k++) begin
        add(0, $urandom_range(30, 1), (k == 2) || ($urandom_range(99) < 80), 10);
        add(1, $urandom_range(30, 1), (k == 2) || ($urandom_range(99) < 80), 10);
      end
      drain(8000);
    end
    vprob0 = 100; vprob1 = 100; rprob = 100;

    // Asynchronous reset in the middle of a burst
    add(0, 50, 1'b1, 0);
    wait_src0_le(40, 200);
    @(posedge clock);
    #3 resetApp_n = 1'b0;
    #1;
    chk("async_grant", grant, 2'b00);
    chk("async_pixelWrite", pixelWrite, 1'b0);
    chk("async_ready", {req0Ready, req1Ready}, 2'b00);
    chk("async_addr_data", {xAddr, yAddr, pixelData}, '0);
    chk("async_rangeError", rangeError, 1'b0);
    drv_en = 1'b0;
    src0.delete(); src1.delete(); exp0.delete(); exp1.delete();
    repeat (2) @(posedge clock);
    #2 resetApp_n = 1'b1;
    add(0, 1, 1'b1, 0);
    add(1, 1, 1'b1, 0);
    drv_en = 1'b1;
    drain(200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
